// File: rtl/bp_resolve_unit.sv
// bp_resolve_unit
//   Execute-side branch resolution. Compares the actual outcome of each
//   accepted branch with the prediction carried down from fetch.
//   On a misprediction it issues a registered one-cycle redirect.
//   Every accepted branch is queued as a training record, and the queue
//   drains to the predictor write port through a valid/ready handshake.
//
// Optional feature (macro BP_UPDATE_COALESCE_EN):
//   A branch whose pc matches the newest queued record overwrites that
//   record instead of allocating a new one.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   ex_valid / ex_ready        exe handshake; ex_ready = !full
//   ex_is_branch               only branches are accepted
//   ex_pc, ex_taken, ex_target actual outcome
//   ex_pred_taken/_target      prediction made at fetch
//   redirect_valid/_pc         registered one-cycle restart request
//   upd_valid/_ready           training record handshake (FIFO head)
//   upd_pc, upd_dest, upd_taken  head record fields
//   branch_cnt, mispredict_cnt   wrapping performance counters
module bp_resolve_unit #(
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ex_valid,
  output logic                 ex_ready,
  input  logic                 ex_is_branch,
  input  logic [31:0]          ex_pc,
  input  logic                 ex_taken,
  input  logic [31:0]          ex_target,
  input  logic                 ex_pred_taken,
  input  logic [31:0]          ex_pred_target,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_pc,
  output logic                 upd_valid,
  input  logic                 upd_ready,
  output logic [31:0]          upd_pc,
  output logic [31:0]          upd_dest,
  output logic                 upd_taken,
  output logic [CNT_WIDTH-1:0] branch_cnt,
  output logic [CNT_WIDTH-1:0] mispredict_cnt
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [31:0]          pc_q    [DEPTH];
  logic [31:0]          dest_q  [DEPTH];
  logic                 taken_q [DEPTH];
  logic [AW-1:0]        rd_ptr_q, wr_ptr_q;
  logic [AW:0]          count_q, count_d;
  logic                 redirect_valid_q;
  logic [31:0]          redirect_pc_q;
  logic [CNT_WIDTH-1:0] branch_cnt_q, mispredict_cnt_q;

  logic full, acc, mp, deq, enq, coal_hit;

  assign full      = (count_q == DEPTH_C);
  assign upd_valid = (count_q != '0);
  assign deq       = upd_valid && upd_ready;

`ifdef BP_UPDATE_COALESCE_EN
  logic [AW-1:0] last_idx;
  assign last_idx = wr_ptr_q - AW'(1);
  // The newest record is only being dequeued when it is also the head.
  // When full, count > 1, so this term never makes ex_ready see upd_ready.
  assign coal_hit = upd_valid && (pc_q[last_idx] == ex_pc) &&
                    !(deq && (count_q == (AW+1)'(1)));
  assign ex_ready = !full || (ex_valid && ex_is_branch && coal_hit);
`else
  assign coal_hit = 1'b0;
  assign ex_ready = !full;
`endif

  assign acc = ex_valid && ex_ready && ex_is_branch;
  // A not-taken branch never uses its target, so a stale pred_target is harmless.
  assign mp  = (ex_taken != ex_pred_taken) || (ex_taken && (ex_target != ex_pred_target));
  assign enq = acc && !coal_hit;

  always_comb begin
    count_d = count_q;
    case ({enq, deq})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q         <= '0;
      wr_ptr_q         <= '0;
      count_q          <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      count_q          <= count_d;
      redirect_valid_q <= acc && mp;
      if (acc && mp)
        redirect_pc_q <= ex_taken ? ex_target : ex_pc + 32'd8;
      if (acc)
        branch_cnt_q <= branch_cnt_q + CNT_WIDTH'(1);
      if (acc && mp)
        mispredict_cnt_q <= mispredict_cnt_q + CNT_WIDTH'(1);
      if (deq)
        rd_ptr_q <= rd_ptr_q + AW'(1);
      if (enq) begin
        pc_q[wr_ptr_q]    <= ex_pc;
        dest_q[wr_ptr_q]  <= ex_target;
        taken_q[wr_ptr_q] <= ex_taken;
        wr_ptr_q          <= wr_ptr_q + AW'(1);
      end
`ifdef BP_UPDATE_COALESCE_EN
      if (acc && coal_hit) begin
        dest_q[last_idx]  <= ex_target;
        taken_q[last_idx] <= ex_taken;
      end
`endif
    end
  end

  // Storage is not reset; gating keeps the head fields at zero when empty.
  assign upd_pc    = upd_valid ? pc_q[rd_ptr_q]    : '0;
  assign upd_dest  = upd_valid ? dest_q[rd_ptr_q]  : '0;
  assign upd_taken = upd_valid ? taken_q[rd_ptr_q] : 1'b0;

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign branch_cnt     = branch_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_bp_resolve_unit.sv
module tb_bp_resolve_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ex_valid = 1'b0, ex_ready, ex_is_branch = 1'b0;
  logic [31:0] ex_pc = '0, ex_target = '0, ex_pred_target = '0;
  logic        ex_taken = 1'b0, ex_pred_taken = 1'b0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        upd_valid, upd_ready = 1'b0;
  logic [31:0] upd_pc, upd_dest;
  logic        upd_taken;
  logic [31:0] branch_cnt, mispredict_cnt;

  int tests = 0;
  int fails = 0;

  bp_resolve_unit #(.DEPTH(4), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_is_branch(ex_is_branch),
    .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_pc(upd_pc), .upd_dest(upd_dest), .upd_taken(upd_taken),
    .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic br(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                    input logic ptk, input logic [31:0] ptgt);
    ex_valid = 1'b1; ex_is_branch = 1'b1;
    ex_pc = pc; ex_taken = tk; ex_target = tgt;
    ex_pred_taken = ptk; ex_pred_target = ptgt;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    br(32'h80000010, 1'b0, 32'h0, 1'b1, 32'h0);
    tick(); tick();
    tests++; if (redirect_valid !== 1'b0) begin fails++; $display("FAIL reset_rv got %b exp 0", redirect_valid); end
    tests++; if (redirect_pc !== 32'h0) begin fails++; $display("FAIL reset_rpc got %h exp 0", redirect_pc); end
    tests++; if ({upd_valid, upd_pc, upd_dest, upd_taken} !== '0) begin fails++; $display("FAIL reset_upd got %b %h %h %b exp zeros", upd_valid, upd_pc, upd_dest, upd_taken); end
    tests++; if ({branch_cnt, mispredict_cnt} !== 64'h0) begin fails++; $display("FAIL reset_cnt got %0d %0d exp 0 0", branch_cnt, mispredict_cnt); end
    tests++; if (ex_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", ex_ready); end
    ex_valid = 1'b0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_correct_taken();
    upd_ready = 1'b1;
    br(32'hBFC00100, 1'b1, 32'hBFC00200, 1'b1, 32'hBFC00200);
    tick();
    ex_valid = 1'b0;
    tests++; if (redirect_valid !== 1'b0) begin fails++; $display("FAIL ct_rv got %b exp 0", redirect_valid); end
    tests++; if ({upd_valid, upd_pc, upd_dest, upd_taken} !== {1'b1, 32'hBFC00100, 32'hBFC00200, 1'b1})
      begin fails++; $display("FAIL ct_upd got %b %h %h %b exp 1 bfc00100 bfc00200 1", upd_valid, upd_pc, upd_dest, upd_taken); end
    tests++; if (branch_cnt !== 32'd1 || mispredict_cnt !== 32'd0) begin fails++; $display("FAIL ct_cnt got %0d %0d exp 1 0", branch_cnt, mispredict_cnt); end
    tick();
    tests++; if (upd_valid !== 1'b0) begin fails++; $display("FAIL ct_drain got %b exp 0", upd_valid); end
  endtask

  task automatic test_dir_mispredict();
    br(32'h80000010, 1'b0, 32'h12345678, 1'b1, 32'h12345678);
    tick();
    ex_valid = 1'b0;
    tests++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h80000018) begin fails++; $display("FAIL dm_redir got %b %h exp 1 80000018", redirect_valid, redirect_pc); end
    tests++; if (mispredict_cnt !== 32'd1) begin fails++; $display("FAIL dm_cnt got %0d exp 1", mispredict_cnt); end
    tick();
    tests++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'h80000018) begin fails++; $display("FAIL dm_pulse got %b %h exp 0 80000018", redirect_valid, redirect_pc); end
    br(32'hFFFFFFFC, 1'b0, 32'h0, 1'b1, 32'h0);
    tick();
    ex_valid = 1'b0;
    tests++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h00000004) begin fails++; $display("FAIL dm_wrap got %b %h exp 1 00000004", redirect_valid, redirect_pc); end
    tick();
  endtask

  task automatic test_target_mispredict();
    br(32'h00000800, 1'b1, 32'h1000, 1'b1, 32'h2000);
    tick();
    ex_valid = 1'b0;
    tests++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1000) begin fails++; $display("FAIL tm_redir got %b %h exp 1 1000", redirect_valid, redirect_pc); end
    tests++; if (mispredict_cnt !== 32'd3) begin fails++; $display("FAIL tm_cnt got %0d exp 3", mispredict_cnt); end
    tick();
    br(32'h00000800, 1'b0, 32'h1000, 1'b0, 32'h2000);
    tick();
    ex_valid = 1'b0;
    tests++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'h1000) begin fails++; $display("FAIL tm_nt got %b %h exp 0 1000", redirect_valid, redirect_pc); end
    tests++; if (mispredict_cnt !== 32'd3 || branch_cnt !== 32'd5) begin fails++; $display("FAIL tm_nt_cnt got %0d %0d exp 3 5", mispredict_cnt, branch_cnt); end
    // Non-branch with ex_valid: ignored.
    br(32'h00000900, 1'b0, 32'h0, 1'b1, 32'h0);
    ex_is_branch = 1'b0;
    tick();
    ex_valid = 1'b0;
    tests++; if (branch_cnt !== 32'd5 || redirect_valid !== 1'b0) begin fails++; $display("FAIL nonbr got %0d %b exp 5 0", branch_cnt, redirect_valid); end
    tick();
    tests++; if (upd_valid !== 1'b0) begin fails++; $display("FAIL nonbr_q got %b exp 0", upd_valid); end
  endtask

  task automatic test_backpressure();
    logic [31:0] p;
    upd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      p = 32'h100 + 32'(i) * 4;
      br(p, i[0], 32'h200 + 32'(i), i[0], 32'h200 + 32'(i));
      tests++; if (ex_ready !== (i < 4)) begin fails++; $display("FAIL bp_ready%0d got %b exp %b", i, ex_ready, (i < 4)); end
      tick();
    end
    // 5th branch held; head must stay stable while stalled.
    for (int s = 0; s < 2; s++) begin
      tests++; if ({upd_valid, upd_pc, upd_dest, upd_taken} !== {1'b1, 32'h100, 32'h200, 1'b0})
        begin fails++; $display("FAIL bp_stall%0d got %b %h %h %b exp 1 100 200 0", s, upd_valid, upd_pc, upd_dest, upd_taken); end
      tests++; if (ex_ready !== 1'b0) begin fails++; $display("FAIL bp_full%0d got %b exp 0", s, ex_ready); end
      tick();
    end
    upd_ready = 1'b1;
    #1;
    tests++; if (ex_ready !== 1'b0) begin fails++; $display("FAIL bp_nocomb got %b exp 0", ex_ready); end
    for (int k = 0; k < 5; k++) begin
      p = 32'h100 + 32'(k) * 4;
      tests++; if ({upd_valid, upd_pc, upd_dest, upd_taken} !== {1'b1, p, 32'h200 + 32'(k), k[0]})
        begin fails++; $display("FAIL bp_drain%0d got %b %h %h %b exp 1 %h %h %b", k, upd_valid, upd_pc, upd_dest, upd_taken, p, 32'h200 + 32'(k), k[0]); end
      if (k == 1) begin
        tests++; if (ex_ready !== 1'b1) begin fails++; $display("FAIL bp_free got %b exp 1", ex_ready); end
      end
      tick();
      if (k == 1) ex_valid = 1'b0;
    end
    tests++; if (upd_valid !== 1'b0 || branch_cnt !== 32'd10) begin fails++; $display("FAIL bp_end got %b %0d exp 0 10", upd_valid, branch_cnt); end
  endtask

  task automatic test_coalesce();
    int n;
    int exp_n;
    logic exp_tk;
`ifdef BP_UPDATE_COALESCE_EN
    exp_n = 1; exp_tk = 1'b0;
`else
    exp_n = 2; exp_tk = 1'b1;
`endif
    upd_ready = 1'b0;
    br(32'h400, 1'b1, 32'h500, 1'b1, 32'h500);
    tick();
    br(32'h400, 1'b0, 32'h500, 1'b0, 32'h500);
    tick();
    ex_valid = 1'b0;
    tests++; if (upd_taken !== exp_tk || upd_pc !== 32'h400) begin fails++; $display("FAIL co_head got %h %b exp 400 %b", upd_pc, upd_taken, exp_tk); end
    upd_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      if (upd_valid) n++;
      tick();
    end
    tests++; if (n != exp_n) begin fails++; $display("FAIL co_count got %0d exp %0d", n, exp_n); end
    tests++; if (branch_cnt !== 32'd12 || mispredict_cnt !== 32'd3) begin fails++; $display("FAIL co_cnt got %0d %0d exp 12 3", branch_cnt, mispredict_cnt); end
  endtask

  task automatic test_reset_mid();
    upd_ready = 1'b0;
    br(32'h600, 1'b1, 32'h700, 1'b1, 32'h700);
    tick();
    br(32'h604, 1'b1, 32'h900, 1'b0, 32'h0);
    reset = 1'b1;
    tick();
    ex_valid = 1'b0;
    reset = 1'b0;
    tests++; if (redirect_valid !== 1'b0 || upd_valid !== 1'b0) begin fails++; $display("FAIL rm_state got %b %b exp 0 0", redirect_valid, upd_valid); end
    tests++; if (branch_cnt !== 32'd0 || mispredict_cnt !== 32'd0 || ex_ready !== 1'b1) begin fails++; $display("FAIL rm_cnt got %0d %0d %b exp 0 0 1", branch_cnt, mispredict_cnt, ex_ready); end
    tick();
    tests++; if (upd_valid !== 1'b0 || redirect_valid !== 1'b0) begin fails++; $display("FAIL rm_after got %b %b exp 0 0", upd_valid, redirect_valid); end
  endtask

  initial begin
    test_reset();
    test_correct_taken();
    test_dir_mispredict();
    test_target_mispredict();
    test_backpressure();
    test_coalesce();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bp_resolve_unit.md
Name: bp_resolve_unit

Overview:
- Execute-side counterpart of the fetch-stage branch history table.
- Accepts resolved branches from exe together with the prediction carried down the pipe, and detects mispredictions.
- On a misprediction, issues a registered redirect to fetch.
- Buffers predictor training records in a small FIFO and drains them one per cycle to the predictor write port (is_write / executed_branch_pc / dest_pc / is_taken) via a valid/ready handshake.

Parameters:
- DEPTH, 4, update FIFO entries; power of two, ≥2.
- CNT_WIDTH, 32, width of the performance counters.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- ex_valid  in  1  exe presents an instruction this cycle.
- ex_ready  out  1  unit can accept; equals !full.
- ex_is_branch  in  1  instruction is a conditional branch or jump.
- ex_pc  in  32  pc of the executed branch.
- ex_taken  in  1  actual direction.
- ex_target  in  32  actual taken target.
- ex_pred_taken  in  1  direction predicted at fetch.
- ex_pred_target  in  32  target predicted at fetch.
- redirect_valid  out  1  one-cycle pulse, fetch must restart.
- redirect_pc  out  32  restart address.
- upd_valid  out  1  FIFO head valid.
- upd_ready  in  1  predictor accepts the head this cycle.
- upd_pc  out  32  head branch pc (to executed_branch_pc).
- upd_dest  out  32  head taken target (to dest_pc).
- upd_taken  out  1  head direction (to is_taken).
- branch_cnt  out  CNT_WIDTH  branches accepted.
- mispredict_cnt  out  CNT_WIDTH  mispredicts detected.

Behaviour:
- Clock and reset:
  - Single clock clk. Reset is synchronous and active-high.
  - On reset: FIFO empty (rd_ptr = wr_ptr = count = 0); redirect_valid = 0; redirect_pc = 0; upd_valid = 0; upd_pc, upd_dest, upd_taken = 0; counters = 0; ex_ready = 1 in the cycle after reset.
- Accept: `acc = ex_valid && ex_ready && ex_is_branch`. Non-branches with ex_valid are ignored and cause no state change.
- Mispredict, computed combinationally on acc:
  - `mp = (ex_taken != ex_pred_taken) || (ex_taken && ex_target != ex_pred_target)`.
  - A pred_target mismatch on a correctly predicted not-taken branch is not a mispredict.
- Redirect:
  - Registered. If acc && mp in cycle N, then redirect_valid = 1 in cycle N+1 only.
  - `redirect_pc = ex_taken ? ex_target : ex_pc + 8` (delay-slot fallthrough, modulo 2^32 wrap).
  - Otherwise redirect_valid = 0 and redirect_pc holds its last value.
  - Redirect does not depend on FIFO state or upd_ready.
- FIFO:
  - Every acc enqueues {ex_pc, ex_target, ex_taken} at wr_ptr, for correct and incorrect predictions alike.
  - Dequeue when upd_valid && upd_ready.
  - upd_* is driven combinationally from the head entry; `upd_valid = (count != 0)`.
  - Zero-latency bypass is not allowed: an entry enqueued in cycle N is visible at the head no earlier than N+1.
  - Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
  - Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
  - Full (count == DEPTH): ex_ready = 0, no enqueue, exe must stall. A dequeue in the same cycle frees the slot for the next cycle only; ex_ready does not depend combinationally on upd_ready.
  - Empty: upd_valid = 0; upd_ready is ignored.
  - upd_* must stay stable while upd_valid && !upd_ready.
- Counters:
  - branch_cnt += 1 on acc; mispredict_cnt += 1 on acc && mp.
  - Both wrap at 2^CNT_WIDTH.
- Reset mid-operation: pending FIFO entries are discarded, and a pending redirect is cancelled in the reset cycle.

Optional Feature:
- Macro: BP_UPDATE_COALESCE_EN.
- Defined:
  - If acc and the FIFO is non-empty, and the newest entry (wr_ptr-1) has pc == ex_pc and is not being dequeued this cycle, that entry is overwritten with the new {target, taken} and count is unchanged.
  - Coalescing is allowed even when full; in that case ex_ready is forced to 1 for a matching pc.
  - Redirect and counters behave identically.
- Undefined: every acc allocates a new entry, as specified above.

Test Plan:
- Reset: assert reset for 2 cycles with ex_valid = 1 -> all outputs 0, ex_ready = 1, counters 0.
- Correct taken: ex_pc = 0xBFC00100, taken = 1, pred_taken = 1, target = pred_target = 0xBFC00200, upd_ready = 1 -> no redirect; next cycle upd_valid = 1, upd_pc = 0xBFC00100, upd_dest = 0xBFC00200, upd_taken = 1; branch_cnt = 1, mispredict_cnt = 0.
- Direction mispredict: pc = 0x80000010, taken = 0, pred_taken = 1 -> redirect_valid pulses exactly 1 cycle later with redirect_pc = 0x80000018; mispredict_cnt = 1.
  - Variant: pc = 0xFFFFFFFC, taken = 0, mispredicted -> redirect_pc = 0x00000004 (wrap).
- Target mispredict: taken = pred_taken = 1, target = 0x1000, pred_target = 0x2000 -> redirect_pc = 0x1000.
  - Same mismatch with taken = pred_taken = 0 -> no redirect.
- Backpressure: upd_ready = 0, 5 back-to-back branches with DEPTH = 4 -> ex_ready drops after the 4th accept and the 5th is held. Then raise upd_ready -> entries drain in order one per cycle, the 5th is accepted, and upd_* stay stable while stalled.
- Coalesce (macro defined): two consecutive branches with pc = 0x400, taken = 1 then taken = 0, upd_ready = 0 -> count = 1, head upd_taken = 0. Macro undefined -> count = 2.
